// File: rtl/fcs32_chk_if.sv
// Receive beat stream into the FCS checker: one DW-bit word per val_i beat.
// Latency: none, wires only.
// Backpressure: none; the checker accepts every beat the source presents.
// Members: data_i (MS byte first on the wire), val_i, sof_i, eof_i, mod_i
// (valid bytes of the eof beat counted from the MS byte, 0 = whole word).
interface fcs32_chk_if #(
  parameter int DW = 32,
  parameter int MW = 3
);
  logic [DW-1:0] data_i;
  logic          val_i;
  logic          sof_i;
  logic          eof_i;
  logic [MW-1:0] mod_i;

  modport master (output data_i, val_i, sof_i, eof_i, mod_i);
  modport slave  (input  data_i, val_i, sof_i, eof_i, mod_i);
endinterface

// File: rtl/fcs32_chk.sv
// Streaming CRC-32 frame checker: runs CRC over data+FCS, compares with the residue.
// Latency: eof beat accepted on edge N -> final CRC on res_o at N+1 -> verdict at N+2.
// Backpressure: none; a beat is taken every cycle val_i is high, including sof right after eof.
// Ports: pclk_i/prst_i clock and sync active-high reset; rx beat stream; clr_i clears counters;
//        res_o running CRC register; done_o/good_o/bad_o verdict pulse; abort_o dropped frame;
//        good_cnt_o/bad_cnt_o saturating frame counters.
module fcs32_chk #(
  parameter int          DW      = 32,
  parameter int          MW      = 3,
  parameter int          CW      = 16,
  parameter logic [31:0] RESIDUE = 32'hC704DD7B
) (
  input  logic          pclk_i,
  input  logic          prst_i,
  fcs32_chk_if.slave    rx,
  input  logic          clr_i,
  output logic [31:0]   res_o,
  output logic          done_o,
  output logic          good_o,
  output logic          bad_o,
  output logic          abort_o,
  output logic [CW-1:0] good_cnt_o,
  output logic [CW-1:0] bad_cnt_o
);

  localparam int          NB   = DW / 8;
  localparam int          NBW  = $clog2(NB + 1);
  localparam logic [31:0] POLY = 32'h04C11DB7;

  typedef enum logic {IDLE, BODY} state_t;

  // Bytes go MS byte first; bits within a byte go LSB first, which is the
  // Ethernet wire order and is what makes the residue come out as RESIDUE.
  function automatic logic [31:0] crc_bytes(input logic [31:0] c_in,
                                            input logic [DW-1:0] d,
                                            input logic [NBW-1:0] n);
    logic [31:0] c;
    logic [7:0]  b;
    c = c_in;
    for (int i = 0; i < NB; i++) begin
      b = d[DW-1-8*i -: 8];
      if (i < int'(n)) begin
        for (int k = 0; k < 8; k++) begin
          c = {c[30:0], 1'b0} ^ ((c[31] ^ b[k]) ? POLY : 32'h0);
        end
      end
    end
    return c;
  endfunction

  // Accept stage
  state_t          state_q, state_d;
  logic [15:0]     len_q, len_d;
  logic            abort_q, abort_d;
  logic            p_vld_q, p_vld_d;
  logic            p_sof_q, p_sof_d;
  logic            p_eof_q, p_eof_d;
  logic [DW-1:0]   p_dat_q, p_dat_d;
  logic [NBW-1:0]  p_nb_q, p_nb_d;
  logic            p_lenok_q, p_lenok_d;
  // CRC stage
  logic [31:0]     crc_q, crc_d;
  logic            v_vld_q, v_vld_d;
  logic            v_lenok_q, v_lenok_d;
  // Verdict stage
  logic            done_q, done_d;
  logic            good_q, good_d;
  logic            bad_q, bad_d;
  logic [CW-1:0]   gcnt_q, gcnt_d;
  logic [CW-1:0]   bcnt_q, bcnt_d;

  logic [31:0]     mod_w;
  logic [NBW-1:0]  nb;
  logic [16:0]     len_sum;
  logic [15:0]     len_new;
  logic            take;

  assign mod_w = 32'(rx.mod_i);
  // Out-of-range mod_i falls back to a full word.
  assign nb      = (rx.eof_i && mod_w != 32'd0 && mod_w <= NB) ? NBW'(mod_w) : NBW'(NB);
  assign len_sum = (rx.sof_i ? 17'd0 : {1'b0, len_q}) + 17'(nb);
  assign len_new = len_sum[16] ? 16'hFFFF : len_sum[15:0];

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    abort_d   = 1'b0;
    take      = 1'b0;
    p_vld_d   = 1'b0;
    p_sof_d   = p_sof_q;
    p_eof_d   = p_eof_q;
    p_dat_d   = p_dat_q;
    p_nb_d    = p_nb_q;
    p_lenok_d = p_lenok_q;

    if (rx.val_i) begin
      if (rx.sof_i) begin
        // sof inside BODY drops the old frame and restarts on this beat.
        abort_d = (state_q == BODY);
        take    = 1'b1;
        state_d = rx.eof_i ? IDLE : BODY;
      end else if (state_q == BODY) begin
        take    = 1'b1;
        state_d = rx.eof_i ? IDLE : BODY;
      end else begin
        abort_d = 1'b1;
      end
    end

    if (take) begin
      p_vld_d   = 1'b1;
      p_sof_d   = rx.sof_i;
      p_eof_d   = rx.eof_i;
      p_dat_d   = rx.data_i;
      p_nb_d    = nb;
      p_lenok_d = (len_new >= 16'd4);
      len_d     = len_new;
    end

    crc_d     = p_vld_q ? crc_bytes(p_sof_q ? 32'hFFFFFFFF : crc_q, p_dat_q, p_nb_q) : crc_q;
    v_vld_d   = p_vld_q & p_eof_q;
    v_lenok_d = p_lenok_q;

    // crc_q still holds this frame's final CRC here even if the next
    // frame's first beat is being folded in on the same edge.
    done_d = v_vld_q;
    good_d = v_vld_q & v_lenok_q & (crc_q == RESIDUE);
    bad_d  = v_vld_q & ~good_d;

    gcnt_d = gcnt_q;
    bcnt_d = bcnt_q;
    if (clr_i) begin
      gcnt_d = CW'(good_d);
      bcnt_d = CW'(bad_d);
    end else begin
      if (good_d && gcnt_q != {CW{1'b1}}) gcnt_d = gcnt_q + CW'(1);
      if (bad_d  && bcnt_q != {CW{1'b1}}) bcnt_d = bcnt_q + CW'(1);
    end
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      state_q   <= IDLE;
      len_q     <= '0;
      abort_q   <= 1'b0;
      p_vld_q   <= 1'b0;
      p_sof_q   <= 1'b0;
      p_eof_q   <= 1'b0;
      p_dat_q   <= '0;
      p_nb_q    <= '0;
      p_lenok_q <= 1'b0;
      crc_q     <= 32'hFFFFFFFF;
      v_vld_q   <= 1'b0;
      v_lenok_q <= 1'b0;
      done_q    <= 1'b0;
      good_q    <= 1'b0;
      bad_q     <= 1'b0;
      gcnt_q    <= '0;
      bcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      abort_q   <= abort_d;
      p_vld_q   <= p_vld_d;
      p_sof_q   <= p_sof_d;
      p_eof_q   <= p_eof_d;
      p_dat_q   <= p_dat_d;
      p_nb_q    <= p_nb_d;
      p_lenok_q <= p_lenok_d;
      crc_q     <= crc_d;
      v_vld_q   <= v_vld_d;
      v_lenok_q <= v_lenok_d;
      done_q    <= done_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      gcnt_q    <= gcnt_d;
      bcnt_q    <= bcnt_d;
    end
  end

  assign res_o      = crc_q;
  assign done_o     = done_q;
  assign good_o     = good_q;
  assign bad_o      = bad_q;
  assign abort_o    = abort_q;
  assign good_cnt_o = gcnt_q;
  assign bad_cnt_o  = bcnt_q;

endmodule

// File: tb/tb_fcs32_chk.sv
// Bench for fcs32_chk: DW=32, DW=64 and DW=8 (2-bit counters) instances.
// Stimulus pushes expected verdicts into per-instance queues; monitors pop on done_o.
module tb_fcs32_chk;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic good;
    int   gcnt;
    int   bcnt;
    logic chk_res;
    int   cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  exp_t q8[$];
  int   gm[3];
  int   bm[3];
  int   ab_seen32 = 0;

  logic [7:0] fr [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                          8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};

  fcs32_chk_if #(.DW(32), .MW(3)) s32();
  fcs32_chk_if #(.DW(64), .MW(3)) s64();
  fcs32_chk_if #(.DW(8),  .MW(1)) s8();

  logic        clr32 = 1'b0, clr64 = 1'b0, clr8 = 1'b0;
  logic [31:0] res32, res64, res8;
  logic        done32, good32, bad32, ab32;
  logic        done64, good64, bad64, ab64;
  logic        done8, good8, bad8, ab8;
  logic [15:0] gc32, bc32, gc64, bc64;
  logic [1:0]  gc8, bc8;

  fcs32_chk #(.DW(32), .MW(3), .CW(16)) u32 (
    .pclk_i(clk), .prst_i(rst), .rx(s32), .clr_i(clr32), .res_o(res32),
    .done_o(done32), .good_o(good32), .bad_o(bad32), .abort_o(ab32),
    .good_cnt_o(gc32), .bad_cnt_o(bc32));

  fcs32_chk #(.DW(64), .MW(3), .CW(16)) u64 (
    .pclk_i(clk), .prst_i(rst), .rx(s64), .clr_i(clr64), .res_o(res64),
    .done_o(done64), .good_o(good64), .bad_o(bad64), .abort_o(ab64),
    .good_cnt_o(gc64), .bad_cnt_o(bc64));

  fcs32_chk #(.DW(8), .MW(1), .CW(2)) u8 (
    .pclk_i(clk), .prst_i(rst), .rx(s8), .clr_i(clr8), .res_o(res8),
    .done_o(done8), .good_o(good8), .bad_o(bad8), .abort_o(ab8),
    .good_cnt_o(gc8), .bad_cnt_o(bc8));

  function automatic void chk(string nm, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void verify(string tag, exp_t e, logic g, logic b,
                                 int gc, int bc, logic [31:0] rp);
    chk({"good", tag}, g, e.good);
    chk({"bad", tag}, b, !e.good);
    chk({"gcnt", tag}, gc, e.gcnt);
    chk({"bcnt", tag}, bc, e.bcnt);
    chk({"latency", tag}, cyc, e.cyc);
    if (e.chk_res) chk({"res", tag}, rp, 32'hC704DD7B);
  endfunction

  // Monitors: res_o is remembered from the previous falling edge so the
  // final CRC (edge N+1) is checked when the verdict (edge N+2) appears.
  logic [31:0] rp32, rp64, rp8;
  always @(negedge clk) begin
    if (done32 === 1'b1) begin
      if (q32.size() == 0) chk("unexpected_done32", done32, 0);
      else verify("32", q32.pop_front(), good32, bad32, int'(gc32), int'(bc32), rp32);
    end
    if (ab32 === 1'b1) ab_seen32++;
    rp32 = res32;
  end
  always @(negedge clk) begin
    if (done64 === 1'b1) begin
      if (q64.size() == 0) chk("unexpected_done64", done64, 0);
      else verify("64", q64.pop_front(), good64, bad64, int'(gc64), int'(bc64), rp64);
    end
    rp64 = res64;
  end
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) chk("unexpected_done8", done8, 0);
      else verify("8", q8.pop_front(), good8, bad8, int'(gc8), int'(bc8), rp8);
    end
    rp8 = res8;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected verdict for an eof beat taken on edge c; counters modelled here.
  task automatic push(input int inst, input logic good, input logic chk_res,
                      input logic clr, input int c);
    int   mx;
    exp_t e;
    mx = (inst == 2) ? 3 : 65535;
    if (clr) begin
      gm[inst] = good ? 1 : 0;
      bm[inst] = good ? 0 : 1;
    end else if (good) begin
      if (gm[inst] < mx) gm[inst]++;
    end else begin
      if (bm[inst] < mx) bm[inst]++;
    end
    e = '{good, gm[inst], bm[inst], chk_res, c + 2};
    case (inst)
      0: q32.push_back(e);
      1: q64.push_back(e);
      default: q8.push_back(e);
    endcase
  endtask

  // One beat; afterwards the lines carry garbage with val_i low.
  task automatic beat(input int inst, input logic [63:0] d, input logic s,
                      input logic e, input logic [2:0] m);
    case (inst)
      0: begin s32.data_i = d[31:0]; s32.sof_i = s; s32.eof_i = e; s32.mod_i = m; s32.val_i = 1'b1; end
      1: begin s64.data_i = d; s64.sof_i = s; s64.eof_i = e; s64.mod_i = m; s64.val_i = 1'b1; end
      default: begin s8.data_i = d[7:0]; s8.sof_i = s; s8.eof_i = e; s8.mod_i = m[0]; s8.val_i = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    case (inst)
      0: begin s32.val_i = 1'b0; s32.data_i = $urandom; s32.sof_i = 1'($urandom_range(0, 1));
               s32.eof_i = 1'($urandom_range(0, 1)); s32.mod_i = 3'($urandom_range(0, 7)); end
      1: begin s64.val_i = 1'b0; s64.data_i = {$urandom, $urandom}; s64.sof_i = 1'($urandom_range(0, 1));
               s64.eof_i = 1'($urandom_range(0, 1)); s64.mod_i = 3'($urandom_range(0, 7)); end
      default: begin s8.val_i = 1'b0; s8.data_i = 8'($urandom); s8.sof_i = 1'($urandom_range(0, 1));
                     s8.eof_i = 1'($urandom_range(0, 1)); s8.mod_i = 1'($urandom_range(0, 1)); end
    endcase
  endtask

  // The 13-byte "123456789"+FCS frame; flip>=0 inverts that bit of the frame.
  task automatic frame(input int inst, input int flip, input int stall,
                       input bit do_push, input bit clr);
    logic [7:0]  b [16];
    logic [63:0] d;
    int          nb, nbeats, c;
    for (int i = 0; i < 16; i++) b[i] = (i < 13) ? fr[i] : 8'h00;
    if (flip >= 0) b[flip / 8][flip % 8] = ~b[flip / 8][flip % 8];
    nb     = (inst == 0) ? 4 : (inst == 1) ? 8 : 1;
    nbeats = (13 + nb - 1) / nb;
    c      = 0;
    for (int k = 0; k < nbeats; k++) begin
      d = '0;
      for (int j = 0; j < nb; j++) d = {d[55:0], b[k * nb + j]};
      beat(inst, d, k == 0, k == nbeats - 1, (k == nbeats - 1) ? 3'(13 % nb) : 3'd0);
      if (stall > 0 && k == 0) idle(1);
      if (stall > 1 && k == 1) idle(stall - 1);
    end
    c = cyc;
    if (clr) begin
      idle(1);
      clr8 = 1'b1;
      idle(1);
      clr8 = 1'b0;
    end
    if (do_push) push(inst, flip < 0, flip < 0, clr, c);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      gm[i] = 0;
      bm[i] = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s32.val_i = 1'b0; s32.sof_i = 1'b0; s32.eof_i = 1'b0; s32.mod_i = '0; s32.data_i = '0;
    s64.val_i = 1'b0; s64.sof_i = 1'b0; s64.eof_i = 1'b0; s64.mod_i = '0; s64.data_i = '0;
    s8.val_i  = 1'b0; s8.sof_i  = 1'b0; s8.eof_i  = 1'b0; s8.mod_i  = '0; s8.data_i  = '0;
    model_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;

    chk("rst_res32", res32, 32'hFFFFFFFF);
    chk("rst_res64", res64, 32'hFFFFFFFF);
    chk("rst_done32", done32, 0);
    chk("rst_good32", good32, 0);
    chk("rst_bad32", bad32, 0);
    chk("rst_abort32", ab32, 0);
    chk("rst_gcnt32", gc32, 0);
    chk("rst_bcnt32", bc32, 0);

    // DW=32: good, one bit flipped, good with 3 stall cycles
    frame(0, -1, 0, 1, 0);
    frame(0, 13, 0, 1, 0);
    frame(0, -1, 3, 1, 0);

    // sof while in BODY aborts the old frame; IDLE beat without sof aborts too
    beat(0, 64'h31323334, 1'b1, 1'b0, 3'd0);
    beat(0, 64'h35363738, 1'b0, 1'b0, 3'd0);
    frame(0, -1, 0, 1, 0);
    idle(2);
    beat(0, 64'hDEADBEEF, 1'b0, 1'b0, 3'd0);

    // 3-byte single-beat frames (always bad), two of them back to back
    beat(0, 64'h31323300, 1'b1, 1'b1, 3'd3);
    push(0, 1'b0, 1'b0, 1'b0, cyc);
    beat(0, 64'h31323300, 1'b1, 1'b1, 3'd3);
    push(0, 1'b0, 1'b0, 1'b0, cyc);

    // back-to-back good frames
    frame(0, -1, 0, 1, 0);
    frame(0, -1, 0, 1, 0);
    idle(4);

    // reset with a verdict in flight, then reset mid-frame
    frame(0, -1, 0, 0, 0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    model_reset();
    chk("post_rst_gcnt32", gc32, 0);
    chk("post_rst_bcnt32", bc32, 0);
    beat(0, 64'h31323334, 1'b1, 1'b0, 3'd0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3);
    frame(0, -1, 0, 1, 0);

    // DW=64: 2 beats with mod_i=5, good then corrupted
    frame(1, -1, 0, 1, 0);
    frame(1, 40, 0, 1, 0);

    // DW=8 with 2-bit counters: saturation, then clr on the increment edge
    for (int i = 0; i < 4; i++) frame(2, -1, 0, 1, 0);
    idle(4);
    chk("sat_gcnt8", gc8, 3);
    frame(2, -1, 0, 1, 1);
    idle(2);
    clr8 = 1'b1;
    idle(1);
    clr8 = 1'b0;
    chk("clr_gcnt8", gc8, 0);
    chk("clr_bcnt8", bc8, 0);

    idle(6);
    chk("aborts32", ab_seen32, 2);
    chk("pending32", q32.size(), 0);
    chk("pending64", q64.size(), 0);
    chk("pending8", q8.size(), 0);
    chk("final_gcnt32", gc32, gm[0]);
    chk("final_bcnt32", bc32, bm[0]);
    chk("final_gcnt64", gc64, gm[1]);
    chk("final_bcnt64", bc64, bm[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
